// File: rtl/ram_pattern_sequencer_if.sv
// Control, pattern-write and display signals of the RAM pattern sequencer.
// The master drives the controls and the RAM write port; the slave is the sequencer.
interface ram_pattern_sequencer_if #(
    parameter int NB_LEDS = 4,
    parameter int NB_ADDR = 4
);
    logic               i_enable;
    logic [1:0]         i_mode;
    logic [NB_ADDR-1:0] i_last_addr;
    logic               i_wr_en;
    logic [NB_ADDR-1:0] i_wr_addr;
    logic [NB_LEDS-1:0] i_wr_data;
    logic [NB_LEDS-1:0] o_leds;
    logic [3:0]         o_led_r;
    logic               o_done;

    modport master (
        output i_enable, i_mode, i_last_addr, i_wr_en, i_wr_addr, i_wr_data,
        input  o_leds, o_led_r, o_done
    );

    modport slave (
        input  i_enable, i_mode, i_last_addr, i_wr_en, i_wr_addr, i_wr_data,
        output o_leds, o_led_r, o_done
    );
endinterface

// File: rtl/ram_pattern_sequencer.sv
// RAM-backed LED pattern player: steps through pattern RAM addresses 0..last
// at a prescaled rate in loop, one-shot or ping-pong mode, with pause and a
// write port that stays live in every state.
module ram_pattern_sequencer #(
    parameter int NB_LEDS  = 4,
    parameter int NB_ADDR  = 4,
    parameter int NB_PRESC = 25,
    parameter int PRESCALE = 25000000
) (
    input  logic                   clock,
    input  logic                   i_reset,
    ram_pattern_sequencer_if.slave bus
);
    localparam int                  DEPTH     = 2 ** NB_ADDR;
    localparam logic [NB_PRESC-1:0] PRESC_MAX = NB_PRESC'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_UP   = 2'd1,
        S_RUN_DOWN = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    logic [NB_LEDS-1:0]  r_ram [DEPTH];
    state_t              r_state;
    logic [NB_ADDR-1:0]  r_addr;
    logic [NB_ADDR-1:0]  r_last;
    logic [1:0]          r_mode;
    logic [NB_PRESC-1:0] r_presc;
    logic [NB_LEDS-1:0]  r_leds;
    logic [3:0]          r_led_r;
    logic                r_done;

    logic w_run;
    logic w_tick;
    logic w_oneshot;
    logic w_pingpong;

    assign w_run      = (r_state == S_RUN_UP) || (r_state == S_RUN_DOWN);
    assign w_tick     = w_run && bus.i_enable && (r_presc == PRESC_MAX);
    // Mode 2'b11 falls through to loop behaviour.
    assign w_oneshot  = (r_mode == 2'b01);
    assign w_pingpong = (r_mode == 2'b10);

    // Pattern RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (bus.i_wr_en)
            r_ram[bus.i_wr_addr] <= bus.i_wr_data;
    end

    // Sequencer FSM: address stepping, prescaler, registered display and state outputs.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_last  <= '0;
            r_mode  <= 2'b00;
            r_presc <= '0;
            r_leds  <= '0;
            r_led_r <= 4'b0001;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_leds <= '0;
                    if (bus.i_enable) begin
                        r_state <= S_RUN_UP;
                        r_led_r <= 4'b0010;
                        r_addr  <= '0;
                        r_presc <= '0;
                        r_mode  <= bus.i_mode;
                        r_last  <= bus.i_last_addr;
                    end
                end
                S_RUN_UP, S_RUN_DOWN: begin
                    // i_enable low freezes addr, prescaler and display.
                    if (bus.i_enable) begin
                        r_leds  <= r_ram[r_addr];
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_tick) begin
                            if (r_state == S_RUN_UP) begin
                                if (r_addr < r_last) begin
                                    r_addr <= r_addr + 1'b1;
                                end else if (w_pingpong) begin
                                    // A single-entry ping-pong has no down leg.
                                    if (r_last != '0) begin
                                        r_state <= S_RUN_DOWN;
                                        r_led_r <= 4'b0100;
                                        r_addr  <= r_last - 1'b1;
                                    end else begin
                                        r_addr <= '0;
                                    end
                                end else if (w_oneshot) begin
                                    r_state <= S_DONE;
                                    r_led_r <= 4'b1000;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_addr <= '0;
                                end
                            end else begin
                                // Turn at 0 straight to 1 so the endpoint shows only once.
                                if (r_addr != '0) begin
                                    r_addr <= r_addr - 1'b1;
                                end else begin
                                    r_state <= S_RUN_UP;
                                    r_led_r <= 4'b0010;
                                    r_addr  <= NB_ADDR'(1);
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.i_enable) begin
                        r_leds <= r_ram[r_addr];
                    end else begin
                        r_state <= S_IDLE;
                        r_led_r <= 4'b0001;
                        r_done  <= 1'b0;
                        r_addr  <= '0;
                        r_leds  <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_led_r <= 4'b0001;
                end
            endcase
        end
    end

    assign bus.o_leds  = r_leds;
    assign bus.o_led_r = r_led_r;
    assign bus.o_done  = r_done;
endmodule

// File: tb/tb_ram_pattern_sequencer.sv
// Bench for ram_pattern_sequencer (PRESCALE=4). Stimulus pushes the expected
// sequence of output changes, each with the clocks the previous value lasted;
// the monitor pops one entry whenever {o_leds,o_led_r,o_done} changes.
module tb_ram_pattern_sequencer;
    logic clock;
    logic i_reset;

    ram_pattern_sequencer_if #(.NB_LEDS(4), .NB_ADDR(4)) bus ();

    ram_pattern_sequencer #(
        .NB_LEDS(4), .NB_ADDR(4), .NB_PRESC(25), .PRESCALE(4)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    typedef struct packed {
        logic [3:0]  leds;
        logic [3:0]  ledr;
        logic        done;
        logic [15:0] gap;   // clocks the previous value lasted, 0 = unchecked
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic exp_ev(input logic [3:0] l, input logic [3:0] r, input logic d, input int g);
        exp_t e;
        e.leds = l; e.ledr = r; e.done = d; e.gap = 16'(g);
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reset takes effect on the next edge; gap is how long the old value lasted.
    task automatic do_reset(input int g);
        i_reset = 1'b1; bus.i_enable = 1'b0; bus.i_wr_en = 1'b0;
        exp_ev(4'h0, 4'b0001, 1'b0, g);
        cyc(2);
        i_reset = 1'b0;
        cyc(1);
    endtask

    task automatic start(input logic [1:0] m, input logic [3:0] last);
        bus.i_mode = m; bus.i_last_addr = last; bus.i_enable = 1'b1;
    endtask

    // Monitor: compare each observed output change against the queue head.
    initial begin
        logic [8:0] prev;
        logic [8:0] cur;
        int         cyc_n;
        int         last_chg;
        exp_t       e;
        prev = '1; cyc_n = 0; last_chg = 0;
        forever begin
            @(negedge clock);
            cyc_n++;
            cur = {bus.o_leds, bus.o_led_r, bus.o_done};
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d got leds=%h led_r=%b done=%b",
                             cyc_n, cur[8:5], cur[4:1], cur[0]);
                end else begin
                    e = q.pop_front();
                    if ({e.leds, e.ledr, e.done} !== cur) begin
                        failures++;
                        $display("FAIL event_value cyc=%0d got leds=%h led_r=%b done=%b want leds=%h led_r=%b done=%b",
                                 cyc_n, cur[8:5], cur[4:1], cur[0], e.leds, e.ledr, e.done);
                    end
                    if (e.gap != 16'd0) begin
                        checks++;
                        if (cyc_n - last_chg != int'(e.gap)) begin
                            failures++;
                            $display("FAIL hold_clocks cyc=%0d leds=%h got %0d want %0d",
                                     cyc_n, cur[8:5], cyc_n - last_chg, e.gap);
                        end
                    end
                end
                prev     = cur;
                last_chg = cyc_n;
            end
        end
    end

    // Stimulus
    initial begin
        int wait_n;
        i_reset = 1'b1;
        bus.i_enable = 1'b0; bus.i_mode = 2'b00; bus.i_last_addr = 4'd0;
        bus.i_wr_en = 1'b0; bus.i_wr_addr = 4'd0; bus.i_wr_data = 4'd0;
        exp_ev(4'h0, 4'b0001, 1'b0, 0);
        cyc(2);
        i_reset = 1'b0;

        // Load RAM[0..3] = 1,2,4,8
        for (int i = 0; i < 4; i++) begin
            bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'(i); bus.i_wr_data = 4'(1 << i);
            cyc(1);
        end
        bus.i_wr_en = 1'b0;
        cyc(1);

        // Loop, last=3, then reset mid-run
        start(2'b00, 4'd3);
        exp_ev(4'h0, 4'b0010, 1'b0, 0); exp_ev(4'h1, 4'b0010, 1'b0, 1);
        exp_ev(4'h2, 4'b0010, 1'b0, 4); exp_ev(4'h4, 4'b0010, 1'b0, 4);
        exp_ev(4'h8, 4'b0010, 1'b0, 4); exp_ev(4'h1, 4'b0010, 1'b0, 4);
        exp_ev(4'h2, 4'b0010, 1'b0, 4);
        cyc(24);
        do_reset(3);

        // One-shot, last=3, then release from DONE
        start(2'b01, 4'd3);
        exp_ev(4'h0, 4'b0010, 1'b0, 0); exp_ev(4'h1, 4'b0010, 1'b0, 1);
        exp_ev(4'h2, 4'b0010, 1'b0, 4); exp_ev(4'h4, 4'b0010, 1'b0, 4);
        exp_ev(4'h8, 4'b0010, 1'b0, 4); exp_ev(4'h8, 4'b1000, 1'b1, 3);
        cyc(25);
        bus.i_enable = 1'b0;
        exp_ev(4'h0, 4'b0001, 1'b0, 9);
        cyc(4);

        // Ping-pong, last=3
        start(2'b10, 4'd3);
        exp_ev(4'h0, 4'b0010, 1'b0, 0); exp_ev(4'h1, 4'b0010, 1'b0, 1);
        exp_ev(4'h2, 4'b0010, 1'b0, 4); exp_ev(4'h4, 4'b0010, 1'b0, 4);
        exp_ev(4'h8, 4'b0010, 1'b0, 4); exp_ev(4'h8, 4'b0100, 1'b0, 3);
        exp_ev(4'h4, 4'b0100, 1'b0, 1); exp_ev(4'h2, 4'b0100, 1'b0, 4);
        exp_ev(4'h1, 4'b0100, 1'b0, 4); exp_ev(4'h1, 4'b0010, 1'b0, 3);
        exp_ev(4'h2, 4'b0010, 1'b0, 1); exp_ev(4'h4, 4'b0010, 1'b0, 4);
        cyc(36);
        do_reset(3);

        // Ping-pong, last=0: constant 1 until reset
        start(2'b10, 4'd0);
        exp_ev(4'h0, 4'b0010, 1'b0, 0); exp_ev(4'h1, 4'b0010, 1'b0, 1);
        cyc(22);
        do_reset(21);

        // Pause 10 clocks mid-step, then live write and last_addr change
        start(2'b00, 4'd3);
        exp_ev(4'h0, 4'b0010, 1'b0, 0); exp_ev(4'h1, 4'b0010, 1'b0, 1);
        exp_ev(4'h2, 4'b0010, 1'b0, 4);
        cyc(7);
        bus.i_enable = 1'b0;
        cyc(10);
        bus.i_enable = 1'b1;
        exp_ev(4'h4, 4'b0010, 1'b0, 14); exp_ev(4'h8, 4'b0010, 1'b0, 4);
        exp_ev(4'h1, 4'b0010, 1'b0, 4);
        cyc(12);
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd2; bus.i_wr_data = 4'hF;
        bus.i_last_addr = 4'd1;
        exp_ev(4'h2, 4'b0010, 1'b0, 4); exp_ev(4'hF, 4'b0010, 1'b0, 4);
        exp_ev(4'h8, 4'b0010, 1'b0, 4);
        cyc(1);
        bus.i_wr_en = 1'b0;
        cyc(12);
        do_reset(3);

        // Mode 11 behaves as loop; new last=1 takes effect on this start
        start(2'b11, 4'd1);
        exp_ev(4'h0, 4'b0010, 1'b0, 0); exp_ev(4'h1, 4'b0010, 1'b0, 1);
        exp_ev(4'h2, 4'b0010, 1'b0, 4); exp_ev(4'h1, 4'b0010, 1'b0, 4);
        exp_ev(4'h2, 4'b0010, 1'b0, 4);
        cyc(16);
        do_reset(3);

        // Every expected change must have been observed
        wait_n = 0;
        while (q.size() != 0 && wait_n < 20) begin
            cyc(1);
            wait_n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got %0d left want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
